// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between the instruction-fetch
// and load/store channels, with one transaction outstanding at a time.
// Data requests win by default. A starvation counter forces a waiting
// instruction fetch through after STARVE_MAX consecutive denials.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_* / data_*             requester channels: req/wr/size/addr/wstrb/wdata
//                               in; addr_ok (combinational on the grant cycle),
//                               data_ok (one-cycle pulse) and rdata out
//   mem_req, mem_wr, mem_size,
//   mem_addr, mem_wstrb,
//   mem_wdata                   memory request, held stable until mem_addr_ok
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                   memory handshakes and response data
//   arb_busy                    high whenever a transaction is in progress
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_busy
);

    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned DATA_W = 32;

    // Request payload latched on grant and replayed to the memory port.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                grant_inst_c;
    logic                grant_data_c;
    logic                owner_inst_q;
    logic [CNT_W-1:0]    starve_q;
    logic                starved_c;
    mem_cmd_t            inst_cmd_c;
    mem_cmd_t            data_cmd_c;
    mem_cmd_t            cmd_q;
    logic [DATA_W-1:0]   rdata_q;

    assign inst_cmd_c = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                          wstrb: inst_wstrb, wdata: inst_wdata};
    assign data_cmd_c = '{wr: data_wr, size: data_size, addr: data_addr,
                          wstrb: data_wstrb, wdata: data_wdata};

    // Instruction fetch has been denied the maximum number of times in a row.
    assign starved_c = (starve_q == CNT_W'(STARVE_MAX));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_d      = state_q;
        grant_inst_c = 1'b0;
        grant_data_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req && !(inst_req && starved_c)) begin
                    grant_data_c = 1'b1;
                end else if (inst_req) begin
                    grant_inst_c = 1'b1;
                end
                if (grant_inst_c || grant_data_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst_addr_ok = grant_inst_c;
    assign data_addr_ok = grant_data_c;

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_req      <= 1'b0;
            arb_busy     <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
        end else begin
            mem_req      <= (state_d == ISSUE);
            arb_busy     <= (state_d != IDLE);
            inst_data_ok <= (state_d == RESP) && owner_inst_q;
            data_data_ok <= (state_d == RESP) && !owner_inst_q;
        end
    end

    // Grant bookkeeping: payload, owner and starvation count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_q        <= '0;
            owner_inst_q <= 1'b0;
            starve_q     <= '0;
        end else if (grant_inst_c || grant_data_c) begin
            cmd_q        <= grant_inst_c ? inst_cmd_c : data_cmd_c;
            owner_inst_q <= grant_inst_c;
            if (grant_data_c && inst_req) begin
                starve_q <= starved_c ? starve_q : starve_q + CNT_W'(1);
            end else begin
                starve_q <= '0;
            end
        end
    end

    // Response capture; the value persists until the next response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if ((state_q == WAIT) && mem_data_ok) begin
            rdata_q <= mem_rdata;
        end
    end

    assign mem_wr     = cmd_q.wr;
    assign mem_size   = cmd_q.size;
    assign mem_addr   = cmd_q.addr;
    assign mem_wstrb  = cmd_q.wstrb;
    assign mem_wdata  = cmd_q.wdata;
    assign inst_rdata = rdata_q;
    assign data_rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic        arb_busy;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    int errors = 0;
    int checks = 0;

    // stimulus controls: req_mode 0 = manual, 1 = random, 2 = always re-request
    int          req_mode = 0;
    bit          auto_mem = 0;
    bit          mem_rand = 0;
    bit          model_en = 0;
    bit          log_grants = 0;
    int          acc_cfg, resp_cfg;
    logic [31:0] rdata_cfg;

    // memory responder: phase 0 idle, 1 waiting to accept, 2 waiting to respond
    int          m_phase = 0;
    int          m_cnt;
    bit          acc_now, dok_now;
    logic [31:0] dok_val;

    bit          i_aok_s, d_aok_s;
    bit          grants[$];
    bit          exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // transaction-level reference model
    bit          sb_busy = 0;
    bit          sb_inst, sb_acc, sb_due;
    int          sb_cnt = 0;
    logic [70:0] sb_cmd;
    logic [31:0] sb_due_val, sb_rd;

    typedef struct {
        bit          ireq, dreq, dwr;
        logic [31:0] addr;
        int          acc, resp;
        logic [31:0] rdata;
        bit          exp_iaok, exp_daok;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mem_step();
        if (m_phase == 0 && mem_req) begin
            m_phase = 1;
            m_cnt   = mem_rand ? int'($urandom_range(3, 0)) : acc_cfg;
        end
        case (m_phase)
            0: begin
                if (mem_rand && $urandom_range(3, 0) == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = $urandom;
                    mem_addr_ok = 1'($urandom_range(1, 0));
                end
            end
            1: begin
                if (mem_rand && $urandom_range(3, 0) == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = $urandom;
                end
                if (m_cnt == 0) begin
                    mem_addr_ok = 1'b1;
                    acc_now     = 1'b1;
                    m_phase     = 2;
                    m_cnt       = mem_rand ? int'($urandom_range(3, 0)) : resp_cfg;
                end else begin
                    m_cnt--;
                end
            end
            default: begin
                if (m_cnt == 0) begin
                    dok_val     = mem_rand ? 32'($urandom) : rdata_cfg;
                    mem_data_ok = 1'b1;
                    mem_rdata   = dok_val;
                    dok_now     = 1'b1;
                    m_phase     = 0;
                end else begin
                    m_cnt--;
                    if (mem_rand && $urandom_range(3, 0) == 0) mem_addr_ok = 1'b1;
                end
            end
        endcase
    endtask

    // First half of a cycle: requesters and memory react just after the edge.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        if (inst_req && i_aok_s) inst_req = 1'b0;
        if (data_req && d_aok_s) data_req = 1'b0;
        i_aok_s = 1'b0;
        d_aok_s = 1'b0;
        if (req_mode != 0) begin
            if (!inst_req && (req_mode == 2 || $urandom_range(1, 0) == 1)) begin
                inst_req   = 1'b1;
                inst_wr    = 1'($urandom_range(1, 0));
                inst_size  = 2'($urandom_range(2, 0));
                inst_addr  = $urandom;
                inst_wstrb = 4'($urandom);
                inst_wdata = $urandom;
            end
            if (!data_req && (req_mode == 2 || $urandom_range(1, 0) == 1)) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(1, 0));
                data_size  = 2'($urandom_range(2, 0));
                data_addr  = $urandom;
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
        end
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        acc_now     = 1'b0;
        dok_now     = 1'b0;
        if (auto_mem) mem_step();
    endtask

    task automatic model_check();
        bit win_i, gi, gd;
        if (!sb_busy) begin
            if (inst_req && data_req) win_i = (sb_cnt == STARVE_MAX);
            else                      win_i = inst_req;
            gi = inst_req && win_i;
            gd = data_req && !win_i;
            chk("m_inst_addr_ok", 64'(inst_addr_ok), 64'(gi));
            chk("m_data_addr_ok", 64'(data_addr_ok), 64'(gd));
            chk("m_idle_busy", 64'({arb_busy, mem_req}), 64'(0));
            chk("m_idle_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
            if (gi || gd) begin
                sb_busy = 1;
                sb_inst = gi;
                sb_acc  = 0;
                sb_due  = 0;
                sb_cmd  = gi ? {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata}
                             : {data_wr, data_size, data_addr, data_wstrb, data_wdata};
                sb_cnt  = (gd && inst_req) ? sb_cnt + 1 : 0;
            end
        end else begin
            chk("m_busy_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
            chk("m_busy", 64'(arb_busy), 64'(1));
            chk("m_mem_req", 64'(mem_req), 64'(!sb_acc));
            if (acc_now) begin
                chk("m_mem_addr", 64'(mem_addr), 64'(sb_cmd[67:36]));
                chk("m_mem_fields", 64'({mem_wr, mem_size, mem_wstrb, mem_wdata}),
                    64'({sb_cmd[70:68], sb_cmd[35:0]}));
                sb_acc = 1;
            end
            if (sb_due) begin
                chk("m_resp_owner", 64'({inst_data_ok, data_data_ok}), 64'({sb_inst, !sb_inst}));
                sb_rd   = sb_due_val;
                sb_busy = 0;
            end else begin
                chk("m_data_ok_quiet", 64'({inst_data_ok, data_data_ok}), 64'(0));
            end
            if (dok_now) begin
                sb_due     = 1;
                sb_due_val = dok_val;
            end
        end
        chk("m_rdata", 64'({inst_rdata, data_rdata}), 64'({sb_rd, sb_rd}));
    endtask

    // Second half of a cycle: sample settled outputs mid-cycle.
    task automatic end_cycle();
        @(negedge clk);
        i_aok_s = inst_addr_ok;
        d_aok_s = data_addr_ok;
        if (log_grants) begin
            if (inst_addr_ok) grants.push_back(1'b1);
            if (data_addr_ok) grants.push_back(1'b0);
        end
        if (model_en) model_check();
    endtask

    task automatic wait_dok(output int lat);
        lat = 0;
        do begin
            begin_cycle();
            end_cycle();
            lat++;
        end while (!(inst_data_ok || data_data_ok) && lat < 40);
    endtask

    task automatic drain();
        int n = 0;
        req_mode = 0;
        while ((sb_busy || inst_req || data_req || arb_busy) && n < 200) begin
            begin_cycle();
            end_cycle();
            n++;
        end
        chk("drain_done", 64'(n < 200), 64'(1));
    endtask

    initial begin
        int lat;
        resetn    = 1'b0;
        {inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata} = '0;
        {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;

        vecs[0] = '{ireq:1, dreq:0, dwr:0, addr:32'h0000_1000, acc:0, resp:0,
                    rdata:32'h1111_1111, exp_iaok:1, exp_daok:0, exp_lat:3};
        vecs[1] = '{ireq:0, dreq:1, dwr:0, addr:32'h0000_2004, acc:2, resp:1,
                    rdata:32'h2222_2222, exp_iaok:0, exp_daok:1, exp_lat:6};
        vecs[2] = '{ireq:1, dreq:1, dwr:0, addr:32'h0000_3008, acc:1, resp:0,
                    rdata:32'h3333_3333, exp_iaok:0, exp_daok:1, exp_lat:4};
        vecs[3] = '{ireq:0, dreq:1, dwr:1, addr:32'h0000_400C, acc:0, resp:3,
                    rdata:32'h4444_4444, exp_iaok:0, exp_daok:1, exp_lat:6};
        vecs[4] = '{ireq:1, dreq:1, dwr:1, addr:32'h0000_5010, acc:0, resp:0,
                    rdata:32'h5555_5555, exp_iaok:0, exp_daok:1, exp_lat:3};

        // reset values
        begin_cycle(); end_cycle();
        begin_cycle(); end_cycle();
        chk("rst_status", 64'({arb_busy, mem_req, inst_addr_ok, data_addr_ok,
                               inst_data_ok, data_data_ok}), 64'(0));
        chk("rst_mem_fields", 64'({mem_wr, mem_size, mem_addr}), 64'(0));
        chk("rst_rdata", 64'({inst_rdata, data_rdata}), 64'(0));
        resetn = 1'b1;

        // lone instruction read with exact cycle timing
        begin_cycle();
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1C00_0000;
        end_cycle();
        chk("lone_addr_ok", 64'({inst_addr_ok, data_addr_ok, mem_req}), 64'(3'b100));
        begin_cycle(); mem_addr_ok = 1'b1; end_cycle();
        chk("lone_issue", 64'({mem_req, arb_busy, inst_data_ok}), 64'(3'b110));
        chk("lone_mem_addr", 64'(mem_addr), 64'(32'h1C00_0000));
        begin_cycle(); end_cycle();
        chk("lone_wait_req", 64'(mem_req), 64'(0));
        begin_cycle(); mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; end_cycle();
        chk("lone_no_early_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
        begin_cycle(); mem_rdata = '0; end_cycle();
        chk("lone_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(2'b10));
        chk("lone_rdata", 64'(inst_rdata), 64'(32'h1234_5678));
        begin_cycle(); end_cycle();
        chk("lone_back_idle", 64'({inst_data_ok, arb_busy}), 64'(0));

        // stray handshakes while idle
        begin_cycle(); mem_data_ok = 1'b1; mem_addr_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0; end_cycle();
        chk("stray_idle_busy", 64'({arb_busy, mem_req}), 64'(0));
        begin_cycle(); end_cycle();
        chk("stray_idle_after", 64'({inst_data_ok, data_data_ok, arb_busy}), 64'(0));
        chk("stray_idle_rdata", 64'(data_rdata), 64'(32'h1234_5678));

        // data write with a stalled memory and a stray response during ISSUE
        begin_cycle();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80;
        data_wstrb = 4'h3; data_wdata = 32'hDEAD_BEEF;
        end_cycle();
        chk("stall_grant", 64'({inst_addr_ok, data_addr_ok}), 64'(2'b01));
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            if (i == 0) begin mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD; end
            if (i == 3) mem_addr_ok = 1'b1;
            end_cycle();
            chk("stall_mem_req", 64'(mem_req), 64'(1));
            chk("stall_mem_addr", 64'(mem_addr), 64'(32'h80));
            chk("stall_mem_fields", 64'({mem_wr, mem_size, mem_wstrb, mem_wdata}),
                64'({1'b1, 2'd2, 4'h3, 32'hDEAD_BEEF}));
        end
        begin_cycle(); end_cycle();
        chk("stall_wait", 64'({mem_req, arb_busy}), 64'(2'b01));
        chk("stall_stray_ignored", 64'(data_rdata), 64'(32'h1234_5678));
        begin_cycle(); mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D; end_cycle();
        chk("stall_no_early_ok", 64'(data_data_ok), 64'(0));
        begin_cycle(); end_cycle();
        chk("stall_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(2'b01));
        chk("stall_rdata", 64'(data_rdata), 64'(32'hCAFE_F00D));
        begin_cycle(); end_cycle();
        chk("stall_idle", 64'({data_data_ok, arb_busy}), 64'(0));

        // table-driven grant/latency vectors
        auto_mem = 1; mem_rand = 0; m_phase = 0;
        foreach (vecs[k]) begin
            begin_cycle();
            inst_req = vecs[k].ireq; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = vecs[k].addr;
            data_req = vecs[k].dreq; data_wr = vecs[k].dwr; data_size = 2'd1;
            data_addr = vecs[k].addr ^ 32'h100; data_wstrb = 4'hC; data_wdata = ~vecs[k].addr;
            acc_cfg = vecs[k].acc; resp_cfg = vecs[k].resp; rdata_cfg = vecs[k].rdata;
            end_cycle();
            chk($sformatf("vec%0d_addr_ok", k), 64'({inst_addr_ok, data_addr_ok}),
                64'({vecs[k].exp_iaok, vecs[k].exp_daok}));
            wait_dok(lat);
            chk($sformatf("vec%0d_lat", k), 64'(lat), 64'(vecs[k].exp_lat));
            chk($sformatf("vec%0d_owner", k), 64'({inst_data_ok, data_data_ok}),
                64'({vecs[k].exp_iaok, vecs[k].exp_daok}));
            chk($sformatf("vec%0d_rdata", k), 64'(inst_rdata), 64'(vecs[k].rdata));
            if (vecs[k].ireq && vecs[k].dreq) begin
                begin_cycle(); end_cycle();
                chk($sformatf("vec%0d_loser_grant", k), 64'({inst_addr_ok, data_addr_ok}), 64'(2'b10));
                wait_dok(lat);
                chk($sformatf("vec%0d_loser_lat", k), 64'(lat), 64'(vecs[k].exp_lat));
                chk($sformatf("vec%0d_loser_owner", k), 64'({inst_data_ok, data_data_ok}), 64'(2'b10));
            end
            begin_cycle(); end_cycle();
        end

        // starvation: both requesters always pending
        mem_rand = 1; m_phase = 0; model_en = 1; sb_busy = 0; sb_cnt = 0;
        sb_rd = vecs[4].rdata;
        log_grants = 1; grants.delete(); req_mode = 2;
        for (int n = 0; n < 500 && grants.size() < 10; n++) begin
            begin_cycle(); end_cycle();
        end
        drain();
        log_grants = 0;
        chk("starve_grant_count", 64'(grants.size() >= 10), 64'(1));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve_order[%0d]", i),
                64'(i < grants.size() ? grants[i] : 1'bx), 64'(exp_order[i]));
        end

        // random traffic against the reference model
        req_mode = 1;
        repeat (1500) begin begin_cycle(); end_cycle(); end
        drain();
        model_en = 0; auto_mem = 0;

        // reset in the middle of ISSUE
        begin_cycle();
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h40;
        end_cycle();
        chk("rstmid_grant", 64'(data_addr_ok), 64'(1));
        begin_cycle(); end_cycle();
        chk("rstmid_issue", 64'(mem_req), 64'(1));
        #1 resetn = 1'b0;
        #1;
        chk("rstmid_status", 64'({mem_req, arb_busy, inst_addr_ok, data_addr_ok,
                                  inst_data_ok, data_data_ok}), 64'(0));
        chk("rstmid_fields", 64'({mem_addr, inst_rdata}), 64'(0));
        begin_cycle(); mem_addr_ok = 1'b1; end_cycle();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            begin_cycle(); mem_data_ok = 1'b1; mem_addr_ok = 1'b1; mem_rdata = 32'hFFFF_0000; end_cycle();
            chk("rstmid_quiet", 64'({inst_data_ok, data_data_ok, arb_busy, mem_req}), 64'(0));
        end
        chk("rstmid_rdata", 64'({inst_rdata, data_rdata}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
